fetch_prefetch_unit: RTL and testbench
======================================

// Module: fetch_prefetch_unit
// PURPOSE
//  Parametrised instruction-fetch front end for the pipelined RV32I core; replaces the bare PC register + inst_read logic.
//  Issues sequential requests on the inst-memory handshake and buffers responses in a DEPTH-entry prefetch queue.
//  Hands {pc, inst} to decode via valid/ready; a redirect (branch/jump from MEM) flushes queued and in-flight fetches.
// PARAMETERS
//  XLEN      32           address/instruction width
//  DEPTH     4            prefetch queue entries; power of 2, >= 2
//  RESET_PC  32'h00000060 first fetch address after reset
// PORTS
//  clk          in   1     clock, all state on posedge
//  rst          in   1     reset, synchronous, active-high
//  inst_read    out  1     fetch request; held until inst_resp
//  inst_addr    out  XLEN  fetch address; stable while inst_read=1 and inst_resp=0
//  inst_resp    in   1     1-cycle response strobe; qualifies inst_rdata
//  inst_rdata   in   XLEN  fetched instruction
//  redirect     in   1     flush + restart fetch at redirect_pc
//  redirect_pc  in   XLEN  new PC (bit0 treated as written, caller aligns)
//  deq_valid    out  1     queue head valid
//  deq_ready    in   1     decode accepts head this cycle
//  deq_inst     out  XLEN  head instruction
//  deq_pc       out  XLEN  head PC
// BEHAVIOUR
//  Reset: inst_read=0, inst_addr=RESET_PC, deq_valid=0, count=0, state=IDLE; deq_inst/deq_pc=0.
//  FSM IDLE: fetch_pc held; inst_read=0. -> REQ when (count + pending) < DEPTH and no redirect this cycle.
//  FSM REQ: inst_read=1, inst_addr=fetch_pc. On inst_resp: enqueue {fetch_pc, inst_rdata}, fetch_pc+=4 (wraps mod 2^XLEN);
//    stay REQ (back-to-back, new addr next cycle) if slots remain after this enqueue, else -> IDLE.
//  FSM DROP: in-flight fetch is stale; inst_read=1 kept at old address (memory protocol: never drop read before resp).
//    On inst_resp: data discarded, -> REQ at fetch_pc next cycle.
//  Redirect (priority over every other event in the same cycle): count<=0, head/tail reset, fetch_pc<=redirect_pc,
//    deq_valid=0 next cycle; the same-cycle resp/dequeue is ignored; state -> DROP if REQ without resp this cycle, else -> REQ.
//    Redirect while in DROP: fetch_pc updated, remain DROP. Redirect with resp in REQ: resp discarded, -> REQ.
//  Space reservation: a request is only issued if a slot is guaranteed; enqueue never sees a full queue.
//  Dequeue: deq_valid = (count != 0); pop on deq_valid & deq_ready; simultaneous enq+deq keeps count.
//  Latency: first inst_read cycle immediately after rst deasserts; inst_resp at cycle t -> deq_valid at t+1 (no bypass).
//  Queue pointers are log2(DEPTH) bits, wrap naturally; count is log2(DEPTH)+1 bits.
//  Reset mid-request: all state cleared; the pending memory response (if any) is not tracked; memory is reset too.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs perf_fetch_cnt[31:0] (responses enqueued) and perf_flush_cnt[31:0]
//    (redirect cycles); both saturate at 32'hFFFFFFFF, cleared by rst.
//  Not defined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  fetch_pkg: fetch_state_e {IDLE, REQ, DROP}; fetch_entry_t struct {pc, inst}; RESET_PC default constant.
//  Sub-module fetch_queue: circular FIFO of fetch_entry_t, DEPTH param, enq/deq/flush, count output.
//  Top: FSM, fetch_pc register, reservation check, optional perf counters.
// TESTING
//  1 Reset, inst_resp every 2nd cycle, deq_ready=1 -> addrs 0x60,0x64,0x68...; deq_pc matches, in order.
//  2 deq_ready=0, resp always 1 -> exactly DEPTH(4) enqueues, inst_read=0 after 4th; one pop -> one new request.
//  3 Redirect to 0x200 while inst_read=1 at 0x70, no resp -> DROP; 0x70 data dropped; next inst_addr=0x200, deq_valid stays 0.
//  4 Redirect same cycle as resp and deq -> queue empty next cycle, resp discarded, next inst_addr=redirect_pc.
//  5 Two redirects (0x300 then 0x400) during DROP -> only 0x400 fetched; first delivered deq_pc=0x400.
//  6 FETCH_PERF_CNT_EN: 10 deliveries, 3 redirects -> perf_fetch_cnt=10, perf_flush_cnt=3; rst -> 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end: FSM states, queue entry layout and default reset PC.
package fetch_pkg;

    localparam int FETCH_XLEN = 32;
    localparam logic [FETCH_XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0060;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO of {pc, inst} entries; flush empties it in one cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush_i,
    input  logic                             enq_i,
    input  logic [$bits(fetch_entry_t)-1:0]  enqData_i,
    input  logic                             deq_i,
    output logic [$bits(fetch_entry_t)-1:0]  head_o,
    output logic [$clog2(DEPTH):0]           count_o
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CW   = PTRW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [PTRW-1:0] head_q;
    logic [PTRW-1:0] tail_q;
    logic [CW-1:0]   count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq_i) begin
                tail_q <= tail_q + PTRW'(1);
            end
            if (deq_i) begin
                head_q <= head_q + PTRW'(1);
            end
            case ({enq_i, deq_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq_i && !flush_i) begin
            mem_q[tail_q] <= enqData_i;
        end
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: sequential fetch FSM feeding a prefetch queue, with redirect flush.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/flush performance counters.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = FETCH_XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            inst_read_o,
    output logic [XLEN-1:0] inst_addr_o,
    input  logic            inst_resp_i,
    input  logic [XLEN-1:0] inst_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            deq_valid_o,
    input  logic            deq_ready_i,
    output logic [XLEN-1:0] deq_inst_o,
    output logic [XLEN-1:0] deq_pc_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt_o,
    output logic [31:0]     perf_flush_cnt_o
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_e    state_q;
    logic [XLEN-1:0] fetchPc_q;
    logic [XLEN-1:0] fetchPc_d;
    logic [XLEN-1:0] instAddr_q;
    logic            instRead_q;
    logic [CW-1:0]   count;
    logic [CW-1:0]   countAfterEnq;
    logic            enq;
    logic            deq;
    fetch_entry_t    enqEntry;
    fetch_entry_t    headEntry;

    assign deq_valid_o   = (count != '0);
    assign deq           = deq_valid_o && deq_ready_i && !redirect_i;
    assign enq           = (state_q == REQ) && inst_resp_i && !redirect_i;
    assign enqEntry      = '{pc: fetchPc_q, inst: inst_rdata_i};
    assign fetchPc_d     = fetchPc_q + XLEN'(4);
    assign countAfterEnq = count + CW'(1) - CW'(deq);

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .flush_i  (redirect_i),
        .enq_i    (enq),
        .enqData_i(enqEntry),
        .deq_i    (deq),
        .head_o   (headEntry),
        .count_o  (count)
    );

    // A stale in-flight read keeps its old address in DROP until memory answers it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetchPc_q  <= RESET_PC;
            instAddr_q <= RESET_PC;
            instRead_q <= 1'b0;
        end else if (redirect_i) begin
            fetchPc_q  <= redirect_pc_i;
            instRead_q <= 1'b1;
            if (state_q != IDLE && !inst_resp_i) begin
                state_q <= DROP;
            end else begin
                state_q    <= REQ;
                instAddr_q <= redirect_pc_i;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (count < DEPTH_C) begin
                        state_q    <= REQ;
                        instRead_q <= 1'b1;
                        instAddr_q <= fetchPc_q;
                    end
                end
                REQ: begin
                    if (inst_resp_i) begin
                        fetchPc_q  <= fetchPc_d;
                        instAddr_q <= fetchPc_d;
                        if (countAfterEnq >= DEPTH_C) begin
                            state_q    <= IDLE;
                            instRead_q <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (inst_resp_i) begin
                        state_q    <= REQ;
                        instAddr_q <= fetchPc_q;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    instRead_q <= 1'b0;
                end
            endcase
        end
    end

    assign inst_read_o = instRead_q;
    assign inst_addr_o = instAddr_q;
    assign deq_pc_o    = deq_valid_o ? headEntry.pc   : '0;
    assign deq_inst_o  = deq_valid_o ? headEntry.inst : '0;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perfFetch_q;
    logic [31:0] perfFlush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perfFetch_q <= '0;
            perfFlush_q <= '0;
        end else begin
            if (enq && perfFetch_q != 32'hFFFF_FFFF) begin
                perfFetch_q <= perfFetch_q + 32'd1;
            end
            if (redirect_i && perfFlush_q != 32'hFFFF_FFFF) begin
                perfFlush_q <= perfFlush_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt_o = perfFetch_q;
    assign perf_flush_cnt_o = perfFlush_q;
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: vector table for streaming/backpressure, hand sequences for redirects.
module tb_fetch_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_read;
    logic [31:0] inst_addr;
    logic        inst_resp = 1'b0;
    logic [31:0] inst_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        deq_valid;
    logic        deq_ready = 1'b0;
    logic [31:0] deq_inst;
    logic [31:0] deq_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_prefetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .inst_read_o  (inst_read),
        .inst_addr_o  (inst_addr),
        .inst_resp_i  (inst_resp),
        .inst_rdata_i (inst_rdata),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .deq_valid_o  (deq_valid),
        .deq_ready_i  (deq_ready),
        .deq_inst_o   (deq_inst),
        .deq_pc_o     (deq_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt_o(perf_fetch_cnt),
        .perf_flush_cnt_o(perf_flush_cnt)
`endif
    );

    typedef struct {
        logic        rstIn;
        logic        resp;
        logic [31:0] rdata;
        logic        rdy;
        logic        expRead;
        logic [31:0] expAddr;
        logic        expValid;
        logic [31:0] expPc;
        logic [31:0] expInst;
        logic        chkData;
    } vec_t;

    vec_t vecs [32];
    int   nVec = 0;

    task automatic addVec(input logic r, input logic resp, input logic [31:0] rdata, input logic rdy,
                          input logic eRead, input logic [31:0] eAddr, input logic eValid,
                          input logic [31:0] ePc, input logic [31:0] eInst, input logic chk);
        vecs[nVec] = '{r, resp, rdata, rdy, eRead, eAddr, eValid, ePc, eInst, chk};
        nVec++;
    endtask

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives one cycle's inputs at the falling edge; outputs are stable from the previous rising edge.
    task automatic applyStimulus(input logic r, input logic resp, input logic [31:0] rdata,
                                 input logic redir, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        rst         = r;
        inst_resp   = resp;
        inst_rdata  = rdata;
        redirect    = redir;
        redirect_pc = rpc;
        deq_ready   = rdy;
    endtask

    task automatic checkOutput(input string name, input logic eRead, input logic [31:0] eAddr,
                               input logic eValid, input logic [31:0] ePc, input logic [31:0] eInst,
                               input logic chkData);
        compare({name, " inst_read"}, {31'd0, inst_read}, {31'd0, eRead});
        compare({name, " inst_addr"}, inst_addr, eAddr);
        compare({name, " deq_valid"}, {31'd0, deq_valid}, {31'd0, eValid});
        if (chkData) begin
            compare({name, " deq_pc"}, deq_pc, ePc);
            compare({name, " deq_inst"}, deq_inst, eInst);
        end
    endtask

    initial begin
        // Streaming with a response every second cycle, decode always ready.
        addVec(1, 0, 32'h0,         1, 0, 32'h60, 0, 32'h0,  32'h0,         1);
        addVec(0, 0, 32'h0,         1, 0, 32'h60, 0, 32'h0,  32'h0,         1);
        addVec(0, 1, 32'hA000_0060, 1, 1, 32'h60, 0, 32'h0,  32'h0,         0);
        addVec(0, 0, 32'h0,         1, 1, 32'h64, 1, 32'h60, 32'hA000_0060, 1);
        addVec(0, 1, 32'hA000_0064, 1, 1, 32'h64, 0, 32'h0,  32'h0,         0);
        addVec(0, 0, 32'h0,         1, 1, 32'h68, 1, 32'h64, 32'hA000_0064, 1);
        addVec(0, 1, 32'hA000_0068, 1, 1, 32'h68, 0, 32'h0,  32'h0,         0);
        addVec(0, 0, 32'h0,         1, 1, 32'h6C, 1, 32'h68, 32'hA000_0068, 1);
        addVec(0, 1, 32'hA000_006C, 1, 1, 32'h6C, 0, 32'h0,  32'h0,         0);
        addVec(0, 0, 32'h0,         1, 1, 32'h70, 1, 32'h6C, 32'hA000_006C, 1);
        // Backpressure: queue fills to four, then one pop releases exactly one request.
        addVec(1, 0, 32'h0,         0, 1, 32'h70, 0, 32'h0,  32'h0,         0);
        addVec(0, 1, 32'hB000_0060, 0, 0, 32'h60, 0, 32'h0,  32'h0,         1);
        addVec(0, 1, 32'hB000_0060, 0, 1, 32'h60, 0, 32'h0,  32'h0,         0);
        addVec(0, 1, 32'hB000_0064, 0, 1, 32'h64, 1, 32'h60, 32'hB000_0060, 1);
        addVec(0, 1, 32'hB000_0068, 0, 1, 32'h68, 1, 32'h60, 32'hB000_0060, 1);
        addVec(0, 1, 32'hB000_006C, 0, 1, 32'h6C, 1, 32'h60, 32'hB000_0060, 1);
        addVec(0, 1, 32'h0,         0, 0, 32'h70, 1, 32'h60, 32'hB000_0060, 1);
        addVec(0, 1, 32'h0,         0, 0, 32'h70, 1, 32'h60, 32'hB000_0060, 1);
        addVec(0, 1, 32'h0,         1, 0, 32'h70, 1, 32'h60, 32'hB000_0060, 1);
        addVec(0, 1, 32'h0,         0, 0, 32'h70, 1, 32'h64, 32'hB000_0064, 1);
        addVec(0, 1, 32'hB000_0070, 0, 1, 32'h70, 1, 32'h64, 32'hB000_0064, 1);
        addVec(0, 1, 32'h0,         0, 0, 32'h74, 1, 32'h64, 32'hB000_0064, 1);
        addVec(0, 1, 32'h0,         0, 0, 32'h74, 1, 32'h64, 32'hB000_0064, 1);

        for (int i = 0; i < nVec; i++) begin
            applyStimulus(vecs[i].rstIn, vecs[i].resp, vecs[i].rdata, 1'b0, 32'h0, vecs[i].rdy);
            checkOutput($sformatf("vec%0d", i), vecs[i].expRead, vecs[i].expAddr, vecs[i].expValid,
                        vecs[i].expPc, vecs[i].expInst, vecs[i].chkData);
        end

        // Redirect with no response pending: stale 0x70 read is drained and discarded.
        applyStimulus(1, 0, 32'h0, 0, 32'h0, 1);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1);
        checkOutput("t3 post-reset", 0, 32'h60, 0, 32'h0, 32'h0, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 32'hC000_0060 + 32'(4 * i), 0, 32'h0, 1);
        end
        applyStimulus(0, 0, 32'h0, 1, 32'h200, 1);
        checkOutput("t3 redirect", 1, 32'h70, 1, 32'h6C, 32'hC000_006C, 1);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1);
        checkOutput("t3 drop hold", 1, 32'h70, 0, 32'h0, 32'h0, 0);
        applyStimulus(0, 1, 32'hDEAD_0070, 0, 32'h0, 1);
        checkOutput("t3 drop resp", 1, 32'h70, 0, 32'h0, 32'h0, 0);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1);
        checkOutput("t3 refetch", 1, 32'h200, 0, 32'h0, 32'h0, 0);
        applyStimulus(0, 1, 32'hC000_0200, 0, 32'h0, 1);
        checkOutput("t3 req200", 1, 32'h200, 0, 32'h0, 32'h0, 0);

        // Redirect in the same cycle as a response and a dequeue.
        applyStimulus(0, 1, 32'hBAD0_0204, 1, 32'h500, 1);
        checkOutput("t4 before", 1, 32'h204, 1, 32'h200, 32'hC000_0200, 1);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1);
        checkOutput("t4 flushed", 1, 32'h500, 0, 32'h0, 32'h0, 0);
        applyStimulus(0, 1, 32'hC000_0500, 0, 32'h0, 0);
        checkOutput("t4 req500", 1, 32'h500, 0, 32'h0, 32'h0, 0);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0);
        checkOutput("t4 deliver", 1, 32'h504, 1, 32'h500, 32'hC000_0500, 1);

        // Two redirects while draining: only the last target is fetched.
        applyStimulus(0, 0, 32'h0, 1, 32'h300, 0);
        checkOutput("t5 redirect1", 1, 32'h504, 1, 32'h500, 32'hC000_0500, 1);
        applyStimulus(0, 0, 32'h0, 1, 32'h400, 0);
        checkOutput("t5 redirect2", 1, 32'h504, 0, 32'h0, 32'h0, 0);
        applyStimulus(0, 1, 32'hDEAD_0504, 0, 32'h0, 0);
        checkOutput("t5 drop resp", 1, 32'h504, 0, 32'h0, 32'h0, 0);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0);
        checkOutput("t5 refetch", 1, 32'h400, 0, 32'h0, 32'h0, 0);
        applyStimulus(0, 1, 32'hC000_0400, 0, 32'h0, 1);
        checkOutput("t5 req400", 1, 32'h400, 0, 32'h0, 32'h0, 0);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1);
        checkOutput("t5 deliver", 1, 32'h404, 1, 32'h400, 32'hC000_0400, 1);

`ifdef FETCH_PERF_CNT_EN
        applyStimulus(1, 0, 32'h0, 0, 32'h0, 1);
        applyStimulus(1, 0, 32'h0, 0, 32'h0, 1);
        compare("t6 reset fetch_cnt", perf_fetch_cnt, 32'd0);
        compare("t6 reset flush_cnt", perf_flush_cnt, 32'd0);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 32'hE000_0000 + 32'(i), 0, 32'h0, 1);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 32'h0, 1, 32'h600 + 32'(16 * i), 1);
        end
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1);
        compare("t6 fetch_cnt", perf_fetch_cnt, 32'd10);
        compare("t6 flush_cnt", perf_flush_cnt, 32'd3);
        applyStimulus(1, 0, 32'h0, 0, 32'h0, 1);
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1);
        compare("t6 cleared fetch_cnt", perf_fetch_cnt, 32'd0);
        compare("t6 cleared flush_cnt", perf_flush_cnt, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
